// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared W-bit register,
// with per-owner lock holding capped at LOCK_MAX consecutive grant cycles.
module reg_write_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int LOCK_MAX = 4,
    localparam int OW      = $clog2(N),
    localparam int CW      = $clog2(LOCK_MAX + 1)
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*W-1:0]  wdata,
    output logic [N-1:0]    gnt,
    output logic [OW-1:0]   owner,
    output logic [W-1:0]    Q,
    output logic            upd
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] LOCK  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  q_q, q_d;
    logic          upd_q, upd_d;

    logic [OW-1:0] win;
    logic          any_req;
    logic          own_req;
    logic          hold;

    // Scan from ptr upward with wrap; first asserted request wins.
    always_comb begin
        int unsigned idx;
        win     = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!any_req && req[idx[OW-1:0]]) begin
                any_req = 1'b1;
                win     = idx[OW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        upd_d   = 1'b0;
        own_req = req[owner_q];
        hold    = 1'b0;

        if (state_q == GRANT || state_q == LOCK) begin
            if (own_req) begin
                q_d   = wdata[owner_q*W +: W];
                upd_d = 1'b1;
            end
            hold = own_req && lock[owner_q] && (cnt_q < CW'(LOCK_MAX));
        end

        if (hold) begin
            state_d = LOCK;
            cnt_d   = cnt_q + CW'(1);
        end else if (any_req) begin
            // Re-arbitration goes straight into GRANT; ptr already sits past the old owner.
            state_d = GRANT;
            gnt_d   = N'(1) << win;
            owner_d = win;
            ptr_d   = (win == OW'(N - 1)) ? '0 : win + OW'(1);
            cnt_d   = CW'(1);
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            upd_q   <= upd_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign Q     = q_q;
    assign upd   = upd_q;

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, width of the shared data register.
REQ-003 Parameter LOCK_MAX, default 4, maximum consecutive grant cycles per owner (>=1).
REQ-004 Clk  input  1  clock; all state SHALL change only on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N  per-requester write request, level.
REQ-007 lock  input  N  per-requester hold request; meaningful only while that requester owns the grant.
REQ-008 wdata  input  N*W  concatenated write data; requester i at bits [i*W +: W].
REQ-009 gnt  output  N  registered one-hot grant, all-zero when idle.
REQ-010 owner  output  clog2(N)  registered index of the current or last granted requester.
REQ-011 Q  output  W  shared register contents.
REQ-012 upd  output  1  registered pulse, high the cycle after Q was written.

Function
REQ-013 FSM states: IDLE (gnt=0), GRANT (first grant cycle of an owner), LOCK (subsequent held cycles).
REQ-014 Arbitration: round-robin from pointer ptr; winner is the first asserted req at index ptr, ptr+1, ... mod N.
REQ-015 IDLE, any req high at edge -> GRANT; gnt=onehot(winner), owner=winner, ptr=winner+1 mod N, cnt=1.
REQ-016 Latency: req seen in cycle k -> gnt high in cycle k+1 -> Q updated at end of k+1 -> upd=1 and new Q visible in k+2.
REQ-017 Write: in any GRANT/LOCK cycle with req[owner]=1, Q SHALL load wdata[owner] at the closing edge, and upd SHALL be 1 the next cycle; otherwise Q holds and upd is 0.
REQ-018 Hold: from GRANT/LOCK, if req[owner]&lock[owner] and cnt<LOCK_MAX -> LOCK, same gnt, cnt+1.
REQ-019 Release: otherwise, if any req is high, re-arbitrate from ptr directly into GRANT (no idle bubble); else go to IDLE with gnt=0.
REQ-020 Forced release at cnt==LOCK_MAX SHALL occur even if lock stays high; ptr already points past the owner, so the owner is served last.
REQ-021 Withdrawn request (req[owner]=0 during a grant cycle): no write, grant released per REQ-019.
REQ-022 Only one gnt bit SHALL ever be high; Q SHALL never be written from a non-owner.
REQ-023 lock on a non-owner SHALL have no effect; lock without req SHALL not hold the grant.
REQ-024 ptr wraps N-1 -> 0; cnt width clog2(LOCK_MAX+1), never exceeds LOCK_MAX.

Reset
REQ-025 While reset=1 at an edge: state=IDLE, gnt=0, owner=0, Q=0, upd=0, ptr=0, cnt=0.
REQ-026 Reset SHALL take priority over any write or grant in the same cycle, including mid-LOCK.
REQ-027 First arbitration after reset SHALL start from index 0.

Verification
REQ-028 Reset, then req=0001, wdata0=8'hA5, lock=0 -> gnt=0001 next cycle, Q=8'hA5 and upd=1 cycle after, then gnt=0.
REQ-029 req=1111 held, lock=0, distinct data -> gnt 0001,0010,0100,1000,0001 on consecutive cycles, Q follows each owner's data, upd high every cycle.
REQ-030 req=0101, lock=0100 held -> gnt=0001 one cycle, then gnt=0100 for exactly 4 cycles (LOCK_MAX=4), then 0001.
REQ-031 req[owner] dropped during its grant cycle -> Q unchanged, upd=0, grant moves to next requester or IDLE.
REQ-032 reset asserted during LOCK -> next cycle gnt=0, Q=0, upd=0; subsequent req=1000|0001 grants 0001 first.
